// File: rtl/vx_commit_counters_pkg.sv
// Shared CSR address map and inhibit bit positions for the commit counters.
// Also provides the address decode used by both the read and write paths.
package vx_commit_counters_pkg;

  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MCYCLE_H      = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MINSTRET_H    = 12'hB82;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

  localparam int INHIBIT_CY = 0;
  localparam int INHIBIT_IR = 2;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_MCYCLE,
    SEL_MCYCLE_H,
    SEL_MINSTRET,
    SEL_MINSTRET_H,
    SEL_INHIBIT
  } csr_sel_e;

  function automatic csr_sel_e csr_decode(input logic [11:0] addr);
    csr_sel_e sel;
    case (addr)
      CSR_MCYCLE:        sel = SEL_MCYCLE;
      CSR_MCYCLE_H:      sel = SEL_MCYCLE_H;
      CSR_MINSTRET:      sel = SEL_MINSTRET;
      CSR_MINSTRET_H:    sel = SEL_MINSTRET_H;
      CSR_MCOUNTINHIBIT: sel = SEL_INHIBIT;
      default:           sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/vx_commit_counters_if.sv
// Commit-update stream, CSR read/write port and live counter taps.
// master = commit stage / CSR unit side, slave = the counter block.
interface vx_commit_counters_if #(
  parameter int CSZ = 5
) ();

  logic           cmt_valid;
  logic [CSZ-1:0] cmt_size;
  logic           csr_wr_valid;
  logic [11:0]    csr_wr_addr;
  logic [31:0]    csr_wr_data;
  logic           csr_rd_valid;
  logic [11:0]    csr_rd_addr;
  logic           csr_rd_rsp_valid;
  logic [31:0]    csr_rd_data;
  logic           csr_rd_err;
  logic [63:0]    instret;
  logic [63:0]    cycles;

  modport master (
    output cmt_valid, cmt_size,
    output csr_wr_valid, csr_wr_addr, csr_wr_data,
    output csr_rd_valid, csr_rd_addr,
    input  csr_rd_rsp_valid, csr_rd_data, csr_rd_err,
    input  instret, cycles
  );

  modport slave (
    input  cmt_valid, cmt_size,
    input  csr_wr_valid, csr_wr_addr, csr_wr_data,
    input  csr_rd_valid, csr_rd_addr,
    output csr_rd_rsp_valid, csr_rd_data, csr_rd_err,
    output instret, cycles
  );

endinterface

// File: rtl/vx_csr_counter64.sv
// 64-bit CSR-writable counter with a single-cycle full-width adder.
// A low-half write drops the whole increment; a high-half write drops only the carry.
module vx_csr_counter64 #(
  parameter int INC_W = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [INC_W-1:0] inc,
  input  logic             inc_en,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [31:0]      wr_data,
  output logic [63:0]      value
);

  logic [63:0] sum;
  logic [63:0] value_nxt;

  assign sum = value + 64'(inc);

  always_comb begin
    value_nxt = inc_en ? sum : value;
    if (wr_lo) begin
      value_nxt[31:0]  = wr_data;
      value_nxt[63:32] = value[63:32];
    end
    // Overwriting the upper word after the add is what discards the carry.
    if (wr_hi) begin
      value_nxt[63:32] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else begin
      value <= value_nxt;
    end
  end

endmodule

// File: rtl/vx_commit_counters.sv
// minstret / mcycle / mcountinhibit block fed by the commit stage.
// Reads return the pre-update value of the request cycle, one cycle later.
module vx_commit_counters
  import vx_commit_counters_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int NUM_SRCS    = 7,
  parameter int CSZ         = $clog2(NUM_SRCS * NUM_THREADS + 1)
) (
  input  logic clk,
  input  logic reset,
  vx_commit_counters_if.slave bus
);

  csr_sel_e    wr_sel;
  csr_sel_e    rd_sel;
  logic        inh_cy;
  logic        inh_ir;
  logic [63:0] mcycle;
  logic [63:0] minstret;
  logic [31:0] rd_data_nxt;
  logic        rd_err_nxt;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;

  assign wr_sel = bus.csr_wr_valid ? csr_decode(bus.csr_wr_addr) : SEL_NONE;
  assign rd_sel = csr_decode(bus.csr_rd_addr);

  vx_csr_counter64 #(.INC_W(1)) u_mcycle (
    .clk     (clk),
    .reset   (reset),
    .inc     (1'b1),
    .inc_en  (!inh_cy),
    .wr_lo   (wr_sel == SEL_MCYCLE),
    .wr_hi   (wr_sel == SEL_MCYCLE_H),
    .wr_data (bus.csr_wr_data),
    .value   (mcycle)
  );

  vx_csr_counter64 #(.INC_W(CSZ)) u_minstret (
    .clk     (clk),
    .reset   (reset),
    .inc     (bus.cmt_size),
    .inc_en  (bus.cmt_valid && !inh_ir),
    .wr_lo   (wr_sel == SEL_MINSTRET),
    .wr_hi   (wr_sel == SEL_MINSTRET_H),
    .wr_data (bus.csr_wr_data),
    .value   (minstret)
  );

  // Inhibit bits are registered, so this cycle's increments still see the old ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inh_cy <= 1'b0;
      inh_ir <= 1'b0;
    end else if (wr_sel == SEL_INHIBIT) begin
      inh_cy <= bus.csr_wr_data[INHIBIT_CY];
      inh_ir <= bus.csr_wr_data[INHIBIT_IR];
    end
  end

  always_comb begin
    rd_data_nxt = '0;
    rd_err_nxt  = 1'b0;
    case (rd_sel)
      SEL_MCYCLE:     rd_data_nxt = mcycle[31:0];
      SEL_MCYCLE_H:   rd_data_nxt = mcycle[63:32];
      SEL_MINSTRET:   rd_data_nxt = minstret[31:0];
      SEL_MINSTRET_H: rd_data_nxt = minstret[63:32];
      SEL_INHIBIT: begin
        rd_data_nxt[INHIBIT_CY] = inh_cy;
        rd_data_nxt[INHIBIT_IR] = inh_ir;
      end
      default:        rd_err_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= bus.csr_rd_valid;
      rsp_data  <= bus.csr_rd_valid ? rd_data_nxt : '0;
      rsp_err   <= bus.csr_rd_valid ? rd_err_nxt : 1'b0;
    end
  end

  assign bus.csr_rd_rsp_valid = rsp_valid;
  assign bus.csr_rd_data      = rsp_data;
  assign bus.csr_rd_err       = rsp_err;
  assign bus.instret          = minstret;
  assign bus.cycles           = mcycle;

endmodule

// File: tb/tb_vx_commit_counters.sv
// Directed bench for vx_commit_counters: read responses and counter snapshots
// are queued by the stimulus and checked by a separate negedge monitor.
module tb_vx_commit_counters;
  import vx_commit_counters_pkg::*;

  localparam int CSZ = $clog2(7 * 4 + 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vx_commit_counters_if #(.CSZ(CSZ)) bus ();

  vx_commit_counters #(.NUM_THREADS(4), .NUM_SRCS(7), .CSZ(CSZ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  typedef struct {
    string       name;
    int          which;  // 0 instret, 1 cycles, 2 {rsp_valid, err, data}
    logic [63:0] exp;
  } chk_t;

  rsp_t        exp_q[$];
  chk_t        chk_q[$];
  int          total = 0;
  int          bad = 0;
  logic        done = 1'b0;
  logic [63:0] cyc_exp = '0;
  logic        cy_inh_m = 1'b0;

  task automatic expect_val(input string name, input int which, input logic [63:0] exp);
    chk_t c;
    c.name  = name;
    c.which = which;
    c.exp   = exp;
    chk_q.push_back(c);
  endtask

  task automatic step(input logic cv, input int cs,
                      input logic wv, input logic [11:0] wa, input logic [31:0] wd,
                      input logic rv, input logic [11:0] ra,
                      input logic [31:0] rexp, input logic rerr);
    bus.cmt_valid    = cv;
    bus.cmt_size     = CSZ'(cs);
    bus.csr_wr_valid = wv;
    bus.csr_wr_addr  = wa;
    bus.csr_wr_data  = wd;
    bus.csr_rd_valid = rv;
    bus.csr_rd_addr  = ra;
    if (rv) exp_q.push_back(rsp_t'{rexp, rerr});
    @(posedge clk);
    #1;
    if (!cy_inh_m) cyc_exp = cyc_exp + 64'd1;
  endtask

  task automatic idle();
    step(0, 0, 0, 12'h0, 32'h0, 0, 12'h0, 32'h0, 0);
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input logic err);
    step(0, 0, 0, 12'h0, 32'h0, 1, a, exp, err);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic cv, input int cs);
    step(cv, cs, 1, a, d, 0, 12'h0, 32'h0, 0);
  endtask

  // Monitor: owns the pass/fail counters.
  always @(negedge clk) begin
    chk_t        c;
    rsp_t        e;
    logic [63:0] act;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      case (c.which)
        0:       act = bus.instret;
        1:       act = bus.cycles;
        default: act = {30'b0, bus.csr_rd_rsp_valid, bus.csr_rd_err, bus.csr_rd_data};
      endcase
      total++;
      if (act !== c.exp) begin
        bad++;
        $display("FAIL %s: got %h, required %h", c.name, act, c.exp);
      end
    end
    if (bus.csr_rd_rsp_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected: got data=%h err=%b, required no response",
                 bus.csr_rd_data, bus.csr_rd_err);
      end else begin
        e = exp_q.pop_front();
        if (bus.csr_rd_data !== e.data || bus.csr_rd_err !== e.err) begin
          bad++;
          $display("FAIL rd_rsp: got data=%h err=%b, required data=%h err=%b",
                   bus.csr_rd_data, bus.csr_rd_err, e.data, e.err);
        end
      end
    end
    if (done) begin
      total++;
      if (exp_q.size() != 0) begin
        bad++;
        $display("FAIL rsp_missing: got %0d outstanding, required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    bus.cmt_valid    = 1'b0;
    bus.cmt_size     = '0;
    bus.csr_wr_valid = 1'b0;
    bus.csr_wr_addr  = '0;
    bus.csr_wr_data  = '0;
    bus.csr_rd_valid = 1'b0;
    bus.csr_rd_addr  = '0;

    #2 reset = 1'b0;
    #1;
    expect_val("rst_instret", 0, 64'd0);
    expect_val("rst_cycles", 1, 64'd0);
    expect_val("rst_rsp", 2, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    repeat (10) idle();
    expect_val("cycles_after_10", 1, 64'd10);
    expect_val("instret_idle", 0, 64'd0);
    rd(CSR_MINSTRET, 32'd0, 1'b0);

    step(1, 4, 0, 12'h0, 32'h0, 0, 12'h0, 32'h0, 0);
    step(1, 3, 0, 12'h0, 32'h0, 0, 12'h0, 32'h0, 0);
    step(1, 28, 0, 12'h0, 32'h0, 0, 12'h0, 32'h0, 0);
    expect_val("instret_sum35", 0, 64'd35);
    step(0, 5, 0, 12'h0, 32'h0, 1, CSR_MINSTRET, 32'd35, 0);
    expect_val("instret_size_ignored", 0, 64'd35);

    wr(CSR_MINSTRET, 32'hFFFF_FFFF, 1, 2);
    expect_val("instret_wr_lo", 0, 64'h0000_0000_FFFF_FFFF);
    step(1, 1, 0, 12'h0, 32'h0, 1, CSR_MINSTRET_H, 32'h0, 0);
    expect_val("instret_carry", 0, 64'h0000_0001_0000_0000);
    rd(CSR_MINSTRET_H, 32'h1, 1'b0);

    wr(CSR_MCOUNTINHIBIT, 32'h4, 0, 0);
    repeat (5) step(1, 4, 0, 12'h0, 32'h0, 0, 12'h0, 32'h0, 0);
    expect_val("instret_ir_frozen", 0, 64'h0000_0001_0000_0000);
    expect_val("cycles_during_ir", 1, cyc_exp);
    wr(CSR_MCOUNTINHIBIT, 32'h0, 1, 4);
    expect_val("instret_ir_old_bits", 0, 64'h0000_0001_0000_0000);
    step(1, 4, 0, 12'h0, 32'h0, 0, 12'h0, 32'h0, 0);
    expect_val("instret_ir_resumed", 0, 64'h0000_0001_0000_0004);

    wr(CSR_MINSTRET_H, 32'h5, 1, 3);
    expect_val("instret_wr_hi", 0, 64'h0000_0005_0000_0007);
    wr(CSR_MINSTRET, 32'hFFFF_FFFE, 0, 0);
    expect_val("instret_wr_lo2", 0, 64'h0000_0005_FFFF_FFFE);
    wr(CSR_MINSTRET_H, 32'h9, 1, 3);
    expect_val("instret_hi_carry_lost", 0, 64'h0000_0009_0000_0001);
    rd(CSR_MINSTRET_H, 32'h9, 1'b0);
    rd(CSR_MINSTRET, 32'h1, 1'b0);

    step(0, 0, 1, 12'h7C0, 32'hDEAD_BEEF, 1, 12'h7C0, 32'h0, 1);
    expect_val("unsupported_wr_ignored", 0, 64'h0000_0009_0000_0001);

    wr(CSR_MCOUNTINHIBIT, 32'hFFFF_FFFF, 0, 0);
    cy_inh_m = 1'b1;
    rd(CSR_MCOUNTINHIBIT, 32'h5, 1'b0);
    idle();
    idle();
    expect_val("cycles_cy_frozen", 1, cyc_exp);
    wr(CSR_MCOUNTINHIBIT, 32'h0, 0, 0);
    cy_inh_m = 1'b0;
    idle();
    expect_val("cycles_cy_resumed", 1, cyc_exp);

    step(0, 0, 1, CSR_MCYCLE, 32'h100, 1, CSR_MCYCLE, cyc_exp[31:0], 0);
    cyc_exp = 64'h100;
    rd(CSR_MCYCLE, 32'h100, 1'b0);
    rd(CSR_MCYCLE, 32'h101, 1'b0);
    idle();
    expect_val("cycles_after_wr", 1, 64'h103);
    rd(12'h7C0, 32'h0, 1'b1);

    // Read response in flight when reset hits: it must vanish and never reappear.
    bus.csr_rd_valid = 1'b1;
    bus.csr_rd_addr  = CSR_MINSTRET_H;
    bus.cmt_valid    = 1'b1;
    bus.cmt_size     = CSZ'(4);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    expect_val("midrst_instret", 0, 64'd0);
    expect_val("midrst_cycles", 1, 64'd0);
    expect_val("midrst_rsp", 2, 64'd0);
    repeat (2) @(negedge clk);
    bus.csr_rd_valid = 1'b0;
    bus.cmt_valid    = 1'b0;
    bus.cmt_size     = '0;
    cyc_exp  = '0;
    cy_inh_m = 1'b0;
    reset    = 1'b1;
    repeat (3) idle();
    expect_val("cycles_after_rerelease", 1, 64'd3);
    expect_val("instret_after_rerelease", 0, 64'd0);

    done = 1'b1;
    repeat (4) @(posedge clk);
    $display("FAIL monitor_timeout: got no summary, required summary");
    $fatal(1, "monitor did not finish");
  end

endmodule
